// File: rtl/pam4_ber_checker.sv
// PAM4 symbol/bit error checker: Gray-maps decided rx levels, compares them with FIFO-buffered
// training levels, aligns by symbol slips and accumulates SER/BER statistics over a fixed window.
module pam4_ber_checker #(
    parameter int SIGNAL_RESOLUTION = 8,
    parameter int LEVEL_WIDTH       = 16,
    parameter int SYMBOL_SEPERATION = 56,
    parameter int FIFO_DEPTH        = 16,
    parameter int LOCK_THRESH       = 8,
    parameter int WINDOW_LEN        = 1024,
    parameter int CNT_WIDTH         = 32
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                start,
    input  logic signed [SIGNAL_RESOLUTION-1:0] ref_level,
    input  logic                                ref_valid,
    input  logic signed [LEVEL_WIDTH-1:0]       rx_level,
    input  logic                                rx_valid,
    output logic [1:0]                          rx_bits,
    output logic                                rx_bits_valid,
    output logic                                locked,
    output logic                                done,
    output logic                                busy,
    output logic [CNT_WIDTH-1:0]                symbol_count,
    output logic [CNT_WIDTH-1:0]                symbol_errors,
    output logic [CNT_WIDTH-1:0]                bit_errors,
    output logic                                overflow,
    output logic                                underflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int RW = $clog2(LOCK_THRESH + 1);
    localparam logic signed [LEVEL_WIDTH-1:0] LVL_N3 = LEVEL_WIDTH'(-(3 * SYMBOL_SEPERATION / 2));
    localparam logic signed [LEVEL_WIDTH-1:0] LVL_N1 = LEVEL_WIDTH'(-(SYMBOL_SEPERATION / 2));
    localparam logic signed [LEVEL_WIDTH-1:0] LVL_P1 = LEVEL_WIDTH'(SYMBOL_SEPERATION / 2);
    localparam logic signed [LEVEL_WIDTH-1:0] LVL_P3 = LEVEL_WIDTH'(3 * SYMBOL_SEPERATION / 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIGN = 2'd1,
        S_COUNT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic [1:0] gray_bits(input logic signed [LEVEL_WIDTH-1:0] lvl);
        case (lvl)
            LVL_N3:  gray_bits = 2'b00;
            LVL_N1:  gray_bits = 2'b01;
            LVL_P1:  gray_bits = 2'b11;
            LVL_P3:  gray_bits = 2'b10;
            default: gray_bits = 2'b00;
        endcase
    endfunction

    function automatic logic gray_legal(input logic signed [LEVEL_WIDTH-1:0] lvl);
        return (lvl == LVL_N3) || (lvl == LVL_N1) || (lvl == LVL_P1) || (lvl == LVL_P3);
    endfunction

    function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        return {1'b0, x[0]} + {1'b0, x[1]};
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [1:0] inc);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + {{(CNT_WIDTH-1){1'b0}}, inc};
        return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
    endfunction

    state_t                 r_state, w_state_next;
    logic [1:0]             r_mem [FIFO_DEPTH];
    logic [AW:0]            r_wr_ptr, r_rd_ptr;
    logic [RW-1:0]          r_run;
    logic [1:0]             r_rx_bits;
    logic                   r_rx_bits_valid, r_locked, r_done, r_busy, r_overflow, r_underflow;
    logic [CNT_WIDTH-1:0]   r_symbol_count, r_symbol_errors, r_bit_errors;

    logic                   w_active, w_empty, w_full, w_pop, w_push, w_under, w_over;
    logic                   w_match, w_slip, w_run_hit, w_window_hit, w_rx_legal;
    logic                   w_locked_next, w_busy_next;
    logic [AW:0]            w_fill, w_rd_step;
    logic [1:0]             w_rx_bits, w_ref_bits, w_head, w_bit_err;
    logic [LEVEL_WIDTH-1:0] w_ref_ext;
    logic [CNT_WIDTH-1:0]   w_cnt_next;

    assign w_ref_ext  = {{(LEVEL_WIDTH-SIGNAL_RESOLUTION){ref_level[SIGNAL_RESOLUTION-1]}}, ref_level};
    assign w_ref_bits = gray_bits(w_ref_ext);
    assign w_rx_bits  = gray_bits(rx_level);
    assign w_rx_legal = gray_legal(rx_level);

    assign w_fill   = r_wr_ptr - r_rd_ptr;
    assign w_empty  = (w_fill == (AW+1)'(0));
    assign w_full   = (w_fill == (AW+1)'(FIFO_DEPTH));
    assign w_head   = r_mem[r_rd_ptr[AW-1:0]];
    assign w_active = (r_state == S_ALIGN) || (r_state == S_COUNT);

    // start takes priority: the restart cycle neither pushes nor pops
    assign w_pop   = w_active && !start && rx_valid && !w_empty;
    assign w_under = w_active && !start && rx_valid && w_empty;
    assign w_push  = w_active && !start && ref_valid && (!w_full || w_pop);
    assign w_over  = w_active && !start && ref_valid && w_full && !w_pop;

    assign w_match   = w_rx_legal && (w_rx_bits == w_head);
    assign w_bit_err = w_rx_legal ? hamming2(w_rx_bits, w_head) : 2'd2;
    assign w_slip    = (r_state == S_ALIGN) && w_pop && !w_match;
    assign w_rd_step = !w_pop ? (AW+1)'(0) :
                       (w_slip && (w_fill >= (AW+1)'(2))) ? (AW+1)'(2) : (AW+1)'(1);

    assign w_run_hit    = (r_state == S_ALIGN) && w_pop && w_match &&
                          (r_run == RW'(LOCK_THRESH - 1));
    assign w_cnt_next   = sat_add(r_symbol_count, 2'd1);
    assign w_window_hit = (r_state == S_COUNT) && w_pop &&
                          (w_cnt_next == CNT_WIDTH'(WINDOW_LEN));

    // State register, with the status flags registered alongside it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_locked <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_locked <= w_locked_next;
            r_busy   <= w_busy_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        if (start) begin
            w_state_next = S_ALIGN;
        end else begin
            case (r_state)
                S_IDLE:  w_state_next = S_IDLE;
                S_ALIGN: w_state_next = w_run_hit ? S_COUNT : S_ALIGN;
                S_COUNT: w_state_next = w_window_hit ? S_DONE : S_COUNT;
                S_DONE:  w_state_next = S_DONE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Output decode from the upcoming state so the flags flip together with it
    always_comb begin
        w_locked_next = (w_state_next == S_COUNT) || (w_state_next == S_DONE);
        w_busy_next   = (w_state_next == S_ALIGN) || (w_state_next == S_COUNT);
    end

    // Reference FIFO storage (contents are don't-care while the pointers say empty)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_ref_bits;
        end
    end

    // FIFO pointers and alignment match run
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_run    <= '0;
        end else if (start) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_run    <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + (AW+1)'(w_push);
            r_rd_ptr <= r_rd_ptr + w_rd_step;
            if ((r_state == S_ALIGN) && w_pop) begin
                r_run <= w_match ? r_run + RW'(1) : RW'(0);
            end
        end
    end

    // Statistics, rx symbol output and sticky FIFO flags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rx_bits       <= 2'b00;
            r_rx_bits_valid <= 1'b0;
            r_done          <= 1'b0;
            r_overflow      <= 1'b0;
            r_underflow     <= 1'b0;
            r_symbol_count  <= '0;
            r_symbol_errors <= '0;
            r_bit_errors    <= '0;
        end else if (start) begin
            r_rx_bits_valid <= 1'b0;
            r_done          <= 1'b0;
            r_overflow      <= 1'b0;
            r_underflow     <= 1'b0;
            r_symbol_count  <= '0;
            r_symbol_errors <= '0;
            r_bit_errors    <= '0;
        end else begin
            r_rx_bits_valid <= w_pop;
            r_done          <= w_window_hit;
            r_overflow      <= r_overflow | w_over;
            r_underflow     <= r_underflow | w_under;
            if (w_pop) begin
                r_rx_bits <= w_rx_bits;
            end
            if ((r_state == S_COUNT) && w_pop) begin
                r_symbol_count <= w_cnt_next;
                if (!w_match) begin
                    r_symbol_errors <= sat_add(r_symbol_errors, 2'd1);
                    r_bit_errors    <= sat_add(r_bit_errors, w_bit_err);
                end
            end
        end
    end

    assign rx_bits       = r_rx_bits;
    assign rx_bits_valid = r_rx_bits_valid;
    assign locked        = r_locked;
    assign done          = r_done;
    assign busy          = r_busy;
    assign symbol_count  = r_symbol_count;
    assign symbol_errors = r_symbol_errors;
    assign bit_errors    = r_bit_errors;
    assign overflow      = r_overflow;
    assign underflow     = r_underflow;

endmodule

// File: tb/tb_pam4_ber_checker.sv
// Directed self-checking bench for pam4_ber_checker (LOCK_THRESH=8, WINDOW_LEN=64, FIFO_DEPTH=16).
module tb_pam4_ber_checker;

    localparam int SR = 8;
    localparam int LW = 16;
    localparam int CW = 32;

    logic                 clk = 1'b0;
    logic                 rstn, start, ref_valid, rx_valid;
    logic signed [SR-1:0] ref_level;
    logic signed [LW-1:0] rx_level;
    logic [1:0]           rx_bits;
    logic                 rx_bits_valid, locked, done, busy, overflow, underflow;
    logic [CW-1:0]        symbol_count, symbol_errors, bit_errors;

    int n_chk  = 0;
    int n_pass = 0;
    int lv [4] = '{-84, -28, 28, 84};
    logic got_done;

    pam4_ber_checker #(
        .SIGNAL_RESOLUTION(8), .LEVEL_WIDTH(16), .SYMBOL_SEPERATION(56),
        .FIFO_DEPTH(16), .LOCK_THRESH(8), .WINDOW_LEN(64), .CNT_WIDTH(32)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .ref_level(ref_level), .ref_valid(ref_valid),
        .rx_level(rx_level), .rx_valid(rx_valid),
        .rx_bits(rx_bits), .rx_bits_valid(rx_bits_valid),
        .locked(locked), .done(done), .busy(busy),
        .symbol_count(symbol_count), .symbol_errors(symbol_errors), .bit_errors(bit_errors),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rv, input int rl, input logic xv, input int xl);
        ref_valid = rv;
        ref_level = SR'(rl);
        rx_valid  = xv;
        rx_level  = LW'(xl);
        tick();
        ref_valid = 1'b0;
        rx_valid  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Leaves the DUT in COUNT with one -84 entry queued and no stats
    task automatic lock_up();
        pulse_start();
        drive(1'b1, -84, 1'b0, 0);
        repeat (8) drive(1'b1, -84, 1'b1, -84);
    endtask

    function automatic int pat(input int k);
        return (k * 7 + k / 5) % 4;
    endfunction

    initial begin
        rstn = 1'b0; start = 1'b0; ref_valid = 1'b0; rx_valid = 1'b0;
        ref_level = '0; rx_level = '0;
        #12 rstn = 1'b1;
        check("rst_flags", {rx_bits, rx_bits_valid, locked, done, busy, overflow, underflow}, 64'd0);
        check("rst_cnt", symbol_count | symbol_errors | bit_errors, 64'd0);
        tick();
        drive(1'b1, -84, 1'b1, -84);
        check("idle_ignore_valid", {rx_bits_valid, busy, underflow, overflow}, 64'd0);

        // Lock with rx lagging ref by 3 symbols and two stale entries to slip past
        pulse_start();
        check("t2_busy", {busy, locked}, 64'b10);
        got_done = 1'b0;
        for (int c = 0; c < 200 && !got_done; c++) begin
            ref_valid = 1'b1;
            ref_level = SR'(lv[pat(c)]);
            rx_valid  = (c >= 5);
            rx_level  = (c >= 5) ? LW'(lv[pat(c - 3)]) : LW'(0);
            tick();
            if (done) got_done = 1'b1;
        end
        ref_valid = 1'b0; rx_valid = 1'b0;
        check("t2_done_seen", got_done, 64'd1);
        check("t2_count", symbol_count, 64'd64);
        check("t2_errs", {symbol_errors, bit_errors}, 64'd0);
        check("t2_lock", {locked, busy, overflow, underflow}, 64'b1000);
        drive(1'b1, 28, 1'b1, 84);
        check("t2_done_pulse", done, 64'd0);
        check("t2_done_hold", {symbol_count, rx_bits_valid, overflow}, {32'd64, 2'b00});

        // Bit weights and illegal level in COUNT
        lock_up();
        check("t3_locked", {locked, busy, symbol_count}, {2'b11, 32'd0});
        drive(1'b1, 28, 1'b1, -84);
        check("t3_match", {rx_bits_valid, rx_bits, symbol_count, symbol_errors}, {3'b100, 32'd1, 32'd0});
        drive(1'b1, -84, 1'b1, 84);
        check("t3_p28_p84", {rx_bits, symbol_errors, bit_errors}, {2'b10, 32'd1, 32'd1});
        drive(1'b1, -84, 1'b1, 84);
        check("t3_n84_p84", {symbol_errors, bit_errors}, {32'd2, 32'd2});
        drive(1'b1, -84, 1'b1, 28);
        check("t3_n84_p28", {rx_bits, symbol_errors, bit_errors}, {2'b11, 32'd3, 32'd4});
        drive(1'b1, -84, 1'b1, 0);
        check("t4_illegal", {rx_bits_valid, rx_bits, symbol_errors, bit_errors}, {3'b100, 32'd4, 32'd6});
        check("t4_count", symbol_count, 64'd5);
        repeat (25) drive(1'b1, -84, 1'b1, -84);
        check("t6_pre_count", {symbol_count, symbol_errors}, {32'd30, 32'd4});

        // Restart mid-COUNT, then confirm the FIFO was flushed
        pulse_start();
        check("t6_cnt_clr", {symbol_count, symbol_errors, bit_errors}, 96'd0);
        check("t6_flags", {locked, busy, done}, 64'b010);
        drive(1'b0, 0, 1'b1, -84);
        check("t6_fifo_empty", {underflow, rx_bits_valid}, 64'b10);

        // Overflow: 16 fill, 17th dropped, push-with-pop accepted, then drain
        pulse_start();
        check("t5_flags_clr", {underflow, overflow}, 64'd0);
        repeat (16) drive(1'b1, -84, 1'b0, 0);
        check("t5_full_no_ovf", overflow, 64'd0);
        drive(1'b1, 84, 1'b0, 0);
        check("t5_ovf", overflow, 64'd1);
        drive(1'b1, -84, 1'b1, -84);
        repeat (16) drive(1'b0, 0, 1'b1, -84);
        check("t5_drained", {locked, symbol_count, symbol_errors}, {1'b1, 32'd9, 32'd0});
        check("t5_no_under", underflow, 64'd0);
        drive(1'b0, 0, 1'b1, -84);
        check("t5_underflow", {underflow, rx_bits_valid, symbol_count}, {2'b10, 32'd9});

        // Asynchronous reset in the middle of COUNT
        lock_up();
        drive(1'b1, -84, 1'b1, 84);
        check("t1_pre", {rx_bits_valid, locked, symbol_errors}, {2'b11, 32'd1});
        #2 rstn = 1'b0;
        #1;
        check("t1_rst_flags", {rx_bits, rx_bits_valid, locked, done, busy, overflow, underflow}, 64'd0);
        check("t1_rst_cnt", {symbol_count, symbol_errors, bit_errors}, 96'd0);
        #2 rstn = 1'b1;
        tick();
        drive(1'b1, -84, 1'b1, -84);
        check("t1_idle", {rx_bits_valid, busy, locked, underflow, overflow}, 64'd0);
        check("t1_idle_cnt", symbol_count, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
